// File: rtl/talco_pe_pkg.sv
// Shared encodings for the TALCO configurable PE: traceback direction codes,
// boundary init selector, convergence tags and the saturating adder.
package talco_pe_pkg;

  localparam logic [1:0] DIR_DIAG  = 2'd0;
  localparam logic [1:0] DIR_HOR   = 2'd1;
  localparam logic [1:0] DIR_VER   = 2'd2;
  localparam logic [1:0] DIR_START = 2'd3;

  typedef enum logic [1:0] {
    INIT_H    = 2'd0,
    INIT_D    = 2'd1,
    INIT_I    = 2'd2,
    INIT_NONE = 2'd3
  } init_state_e;

  typedef enum logic {
    ST_CFG = 1'b0,
    ST_RUN = 1'b1
  } pe_state_e;

  localparam logic [1:0] CONV_TAG_H     = 2'b00;
  localparam logic [1:0] CONV_TAG_I     = 2'b01;
  localparam logic [1:0] CONV_TAG_D     = 2'b10;
  localparam logic [1:0] CONV_TAG_START = 2'b11;

  localparam int CONV_DONT_CARE = 0;

  // Exact sum of two score-width operands, clamped into [lo, hi].
  function automatic int sat_add(input int a, input int b, input int lo, input int hi);
    int s;
    s = a + b;
    if (s < lo) return lo;
    if (s > hi) return hi;
    return s;
  endfunction

endpackage

// File: rtl/talco_pe_subrow.sv
// Substitution score row for this PE's query symbol: one entry per reference
// symbol, synchronous write, combinational read.
module talco_pe_subrow
  import talco_pe_pkg::*;
#(
  parameter int PE_WIDTH  = 16,
  parameter int SYM_WIDTH = 5
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_wr_en,
  input  logic [SYM_WIDTH-1:0]        i_wr_addr,
  input  logic signed [PE_WIDTH-1:0]  i_wr_data,
  input  logic [SYM_WIDTH-1:0]        i_rd_addr,
  output logic signed [PE_WIDTH-1:0]  o_rd_data
);

  localparam int DEPTH = 1 << SYM_WIDTH;

  logic signed [PE_WIDTH-1:0] r_row [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_row[i] <= '0;
    end else if (i_wr_en) begin
      r_row[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_row[i_rd_addr];

endmodule

// File: rtl/talco_pe_cfg.sv
// Configurable affine-gap systolic PE: one H/I/D cell per valid cycle with a
// programmable substitution row, local mode, X-drop flag and running maximum.
module talco_pe_cfg
  import talco_pe_pkg::*;
#(
  parameter int PE_WIDTH          = 16,
  parameter int SYM_WIDTH         = 5,
  parameter int REF_LEN_WIDTH     = 10,
  parameter int QUERY_LEN_WIDTH   = 10,
  parameter int LOG_MAX_TILE_SIZE = 10,
  parameter int PE_IDX            = 0,
  parameter int DONT_CARE_SYM     = (1 << SYM_WIDTH) - 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_wr,
  input  logic [SYM_WIDTH-1:0]             cfg_addr,
  input  logic signed [PE_WIDTH-1:0]       cfg_data,
  input  logic signed [PE_WIDTH-1:0]       cfg_gap_open,
  input  logic signed [PE_WIDTH-1:0]       cfg_gap_extend,
  input  logic signed [PE_WIDTH-1:0]       cfg_xdrop,
  input  logic signed [PE_WIDTH-1:0]       cfg_inf,
  input  logic                             cfg_local,
  input  logic                             cfg_commit,
  input  logic                             tile_start,
  input  logic [1:0]                       init_state,
  input  logic                             block,
  input  logic [LOG_MAX_TILE_SIZE:0]       marker,
  input  logic signed [PE_WIDTH-1:0]       diag_score,
  input  logic [REF_LEN_WIDTH+1:0]         diag_CH,
  input  logic signed [PE_WIDTH-1:0]       H_init_in,
  input  logic signed [PE_WIDTH-1:0]       D_init_in,
  input  logic signed [PE_WIDTH-1:0]       global_max,
  input  logic                             valid_in,
  input  logic [SYM_WIDTH-1:0]             ref_in,
  input  logic [REF_LEN_WIDTH-1:0]         ref_idx_in,
  input  logic [QUERY_LEN_WIDTH-1:0]       query_idx_in,
  input  logic signed [PE_WIDTH-1:0]       H_prev_pe,
  input  logic signed [PE_WIDTH-1:0]       I_prev_pe,
  input  logic [REF_LEN_WIDTH+1:0]         CH_prev_pe,
  input  logic [REF_LEN_WIDTH+1:0]         CI_prev_pe,
  output logic                             valid_out,
  output logic [SYM_WIDTH-1:0]             ref_out,
  output logic [REF_LEN_WIDTH-1:0]         ref_idx_out,
  output logic [QUERY_LEN_WIDTH-1:0]       query_idx_out,
  output logic [3:0]                       dir_out,
  output logic signed [PE_WIDTH-1:0]       H_out,
  output logic signed [PE_WIDTH-1:0]       I_out,
  output logic signed [PE_WIDTH-1:0]       D_out,
  output logic [REF_LEN_WIDTH+1:0]         CH_out,
  output logic [REF_LEN_WIDTH+1:0]         CI_out,
  output logic [REF_LEN_WIDTH+1:0]         CD_out,
  output logic                             xdrop_flag,
  output logic signed [PE_WIDTH-1:0]       max_score,
  output logic [REF_LEN_WIDTH-1:0]         max_ref_idx,
  output logic [QUERY_LEN_WIDTH-1:0]       max_query_idx,
  output logic                             cfg_busy
);

  localparam int                         CW        = REF_LEN_WIDTH + 2;
  localparam int                         POS_MAX   = (1 << (PE_WIDTH - 1)) - 1;
  localparam logic signed [PE_WIDTH-1:0] INF_RESET = PE_WIDTH'(16384);
  localparam logic signed [PE_WIDTH-1:0] MOST_NEG  = {1'b1, {(PE_WIDTH-1){1'b0}}};

  pe_state_e r_state, w_next_state;

  logic signed [PE_WIDTH-1:0] r_go, r_ge, r_xdrop, r_inf;
  logic                       r_local;
  logic signed [PE_WIDTH-1:0] r_diag;
  logic [CW-1:0]              r_diag_ptr;
  logic                       r_first;

  logic                       w_run;
  logic signed [PE_WIDTH-1:0] w_row;
  logic signed [PE_WIDTH-1:0] w_ninf;
  int                         w_ninf_i;
  logic                       w_seed;
  logic                       w_dont_care;
  int w_hup, w_iup, w_hleft, w_dleft, w_diag;
  int w_i_h, w_i_i, w_d_h, w_d_d, w_ival, w_dval, w_hval, w_sum;
  logic                       w_i_sel, w_d_sel;
  logic [1:0]                 w_dir_lo;
  logic [CW-1:0]              w_ch, w_ci, w_cd;
  logic                       w_xdrop;
  logic                       w_max_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_CFG;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (r_state == ST_CFG && cfg_commit) w_next_state = ST_RUN;
  end

  assign w_run    = (r_state == ST_RUN);
  assign cfg_busy = (r_state != ST_RUN);

  // Scalars may be re-committed at any time; the row is only writable before RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_go    <= '0;
      r_ge    <= '0;
      r_xdrop <= '0;
      r_inf   <= INF_RESET;
      r_local <= 1'b0;
    end else if (cfg_commit) begin
      r_go    <= cfg_gap_open;
      r_ge    <= cfg_gap_extend;
      r_xdrop <= cfg_xdrop;
      r_inf   <= cfg_inf;
      r_local <= cfg_local;
    end
  end

  talco_pe_subrow #(
    .PE_WIDTH  (PE_WIDTH),
    .SYM_WIDTH (SYM_WIDTH)
  ) u_subrow (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr_en   (cfg_wr && !w_run),
    .i_wr_addr (cfg_addr),
    .i_wr_data (cfg_data),
    .i_rd_addr (ref_in),
    .o_rd_data (w_row)
  );

  assign w_ninf      = -r_inf;
  assign w_ninf_i    = -int'(r_inf);
  assign w_seed      = (PE_IDX == 0) && !block && r_first &&
                       (init_state_e'(init_state) != INIT_NONE);
  assign w_dont_care = (ref_in == SYM_WIDTH'(DONT_CARE_SYM));

  always_comb begin
    w_hup   = int'(H_prev_pe);
    w_iup   = int'(I_prev_pe);
    w_hleft = r_first ? int'(H_init_in) : int'(H_out);
    w_dleft = r_first ? int'(D_init_in) : int'(D_out);
    w_diag  = (ref_idx_in == '0 && query_idx_in == '0) ? 0 : int'(r_diag);
    if (w_seed) begin
      w_hup   = w_ninf_i;
      w_iup   = w_ninf_i;
      w_hleft = w_ninf_i;
      w_dleft = w_ninf_i;
      w_diag  = w_ninf_i;
      case (init_state_e'(init_state))
        INIT_H:  w_diag  = 0;
        INIT_D:  w_dleft = 0;
        INIT_I:  w_iup   = 0;
        default: ;
      endcase
    end

    w_i_h   = sat_add(w_hup, int'(r_go), w_ninf_i, POS_MAX);
    w_i_i   = sat_add(w_iup, int'(r_ge), w_ninf_i, POS_MAX);
    w_i_sel = (w_i_i > w_i_h);
    w_ival  = w_i_sel ? w_i_i : w_i_h;
    w_d_h   = sat_add(w_hleft, int'(r_go), w_ninf_i, POS_MAX);
    w_d_d   = sat_add(w_dleft, int'(r_ge), w_ninf_i, POS_MAX);
    w_d_sel = (w_d_d > w_d_h);
    w_dval  = w_d_sel ? w_d_d : w_d_h;

    w_hval   = sat_add(w_diag, int'(w_row), w_ninf_i, POS_MAX);
    w_dir_lo = DIR_DIAG;
    if (w_dval > w_hval) begin
      w_hval   = w_dval;
      w_dir_lo = DIR_HOR;
    end
    if (w_ival > w_hval) begin
      w_hval   = w_ival;
      w_dir_lo = DIR_VER;
    end
    if (r_local && w_hval < 0) begin
      w_hval   = 0;
      w_dir_lo = DIR_START;
    end
    if (w_dont_care) w_hval = w_ninf_i;

    // Pointers follow the winning predecessor unless this anti-diagonal is a marker.
    w_ci = w_i_sel ? CI_prev_pe : CH_prev_pe;
    w_cd = w_d_sel ? CD_out : CH_out;
    case (w_dir_lo)
      DIR_DIAG: w_ch = r_diag_ptr;
      DIR_HOR:  w_ch = w_cd;
      DIR_VER:  w_ch = w_ci;
      default:  w_ch = {ref_idx_in, CONV_TAG_START};
    endcase
    w_sum = int'(ref_idx_in) + int'(query_idx_in);
    if (w_sum == int'(marker) - 1) begin
      w_ch = {ref_idx_in, CONV_TAG_START};
      w_ci = {ref_idx_in, CONV_TAG_START};
      w_cd = {ref_idx_in, CONV_TAG_START};
    end else if (w_sum == int'(marker)) begin
      w_ch = {ref_idx_in, CONV_TAG_H};
      w_ci = {ref_idx_in, CONV_TAG_I};
      w_cd = {ref_idx_in, CONV_TAG_D};
    end
    if (w_dont_care) begin
      w_ch = CW'(CONV_DONT_CARE);
      w_ci = CW'(CONV_DONT_CARE);
      w_cd = CW'(CONV_DONT_CARE);
    end

    w_xdrop   = (w_hval + int'(r_xdrop)) < int'(global_max);
    w_max_upd = w_hval > int'(max_score);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out     <= 1'b0;
      ref_out       <= '0;
      ref_idx_out   <= '0;
      query_idx_out <= '0;
      dir_out       <= '0;
      H_out         <= -INF_RESET;
      I_out         <= -INF_RESET;
      D_out         <= -INF_RESET;
      CH_out        <= '0;
      CI_out        <= '0;
      CD_out        <= '0;
      xdrop_flag    <= 1'b0;
      r_diag        <= -INF_RESET;
      r_diag_ptr    <= '0;
      r_first       <= 1'b1;
    end else if (w_run) begin
      valid_out     <= valid_in;
      ref_out       <= ref_in;
      ref_idx_out   <= ref_idx_in;
      query_idx_out <= query_idx_in;
      if (valid_in) begin
        dir_out    <= {w_i_sel, w_d_sel, w_dir_lo};
        H_out      <= PE_WIDTH'(w_hval);
        I_out      <= PE_WIDTH'(w_ival);
        D_out      <= PE_WIDTH'(w_dval);
        CH_out     <= w_ch;
        CI_out     <= w_ci;
        CD_out     <= w_cd;
        xdrop_flag <= w_xdrop;
        r_diag     <= H_prev_pe;
        r_diag_ptr <= CH_prev_pe;
        r_first    <= 1'b0;
      end else begin
        // A gap reloads the diagonal seed and arms the row-boundary path.
        dir_out    <= '0;
        H_out      <= w_ninf;
        I_out      <= w_ninf;
        D_out      <= w_ninf;
        CH_out     <= '0;
        CI_out     <= '0;
        CD_out     <= '0;
        xdrop_flag <= 1'b0;
        r_diag     <= block ? ((PE_IDX == 0) ? diag_score : w_ninf) : H_init_in;
        r_diag_ptr <= (block && PE_IDX == 0) ? diag_CH : '0;
        r_first    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_score     <= MOST_NEG;
      max_ref_idx   <= '0;
      max_query_idx <= '0;
    end else if (tile_start) begin
      max_score     <= MOST_NEG;
      max_ref_idx   <= '0;
      max_query_idx <= '0;
    end else if (w_run && valid_in && w_max_upd) begin
      max_score     <= PE_WIDTH'(w_hval);
      max_ref_idx   <= ref_idx_in;
      max_query_idx <= query_idx_in;
    end
  end

endmodule

// File: tb/tb_talco_pe_cfg.sv
// Directed bench for talco_pe_cfg: drives hand-built cells and compares the
// registered outputs against hand-computed scores, directions and pointers.
module tb_talco_pe_cfg;

  localparam int NINF = -16384;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_wr;
  logic [4:0]         cfg_addr;
  logic signed [15:0] cfg_data, cfg_gap_open, cfg_gap_extend, cfg_xdrop, cfg_inf;
  logic               cfg_local, cfg_commit, tile_start;
  logic [1:0]         init_state;
  logic               block;
  logic [10:0]        marker;
  logic signed [15:0] diag_score;
  logic [11:0]        diag_CH;
  logic signed [15:0] H_init_in, D_init_in, global_max;
  logic               valid_in;
  logic [4:0]         ref_in;
  logic [9:0]         ref_idx_in, query_idx_in;
  logic signed [15:0] H_prev_pe, I_prev_pe;
  logic [11:0]        CH_prev_pe, CI_prev_pe;
  logic               valid_out;
  logic [4:0]         ref_out;
  logic [9:0]         ref_idx_out, query_idx_out;
  logic [3:0]         dir_out;
  logic signed [15:0] H_out, I_out, D_out;
  logic [11:0]        CH_out, CI_out, CD_out;
  logic               xdrop_flag;
  logic signed [15:0] max_score;
  logic [9:0]         max_ref_idx, max_query_idx;
  logic               cfg_busy;

  int totalChecks = 0;
  int badChecks   = 0;

  talco_pe_cfg dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_gap_open(cfg_gap_open), .cfg_gap_extend(cfg_gap_extend), .cfg_xdrop(cfg_xdrop),
    .cfg_inf(cfg_inf), .cfg_local(cfg_local), .cfg_commit(cfg_commit), .tile_start(tile_start),
    .init_state(init_state), .block(block), .marker(marker), .diag_score(diag_score),
    .diag_CH(diag_CH), .H_init_in(H_init_in), .D_init_in(D_init_in), .global_max(global_max),
    .valid_in(valid_in), .ref_in(ref_in), .ref_idx_in(ref_idx_in), .query_idx_in(query_idx_in),
    .H_prev_pe(H_prev_pe), .I_prev_pe(I_prev_pe), .CH_prev_pe(CH_prev_pe), .CI_prev_pe(CI_prev_pe),
    .valid_out(valid_out), .ref_out(ref_out), .ref_idx_out(ref_idx_out),
    .query_idx_out(query_idx_out), .dir_out(dir_out), .H_out(H_out), .I_out(I_out),
    .D_out(D_out), .CH_out(CH_out), .CI_out(CI_out), .CD_out(CD_out), .xdrop_flag(xdrop_flag),
    .max_score(max_score), .max_ref_idx(max_ref_idx), .max_query_idx(max_query_idx),
    .cfg_busy(cfg_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One gap cycle that seeds the diagonal, then one valid cell whose
  // neighbours are all -inf, so H depends only on diag, row and mode.
  task automatic applyStimulus(input int diag, input logic [4:0] sym,
                               input int ridx, input int qidx, input logic ts);
    valid_in  = 1'b0;
    H_init_in = 16'(diag);
    tick();
    valid_in     = 1'b1;
    ref_in       = sym;
    ref_idx_in   = 10'(ridx);
    query_idx_in = 10'(qidx);
    H_init_in    = 16'(NINF);
    D_init_in    = 16'(NINF);
    H_prev_pe    = 16'(NINF);
    I_prev_pe    = 16'(NINF);
    tile_start   = ts;
    tick();
    valid_in   = 1'b0;
    tile_start = 1'b0;
  endtask

  task automatic commitScalars(input logic loc);
    cfg_local  = loc;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_wr = 0; cfg_addr = 0; cfg_data = 0;
    cfg_gap_open = -16'sd4; cfg_gap_extend = -16'sd1; cfg_xdrop = 16'sd10; cfg_inf = 16'sd16384;
    cfg_local = 0; cfg_commit = 0; tile_start = 0; init_state = 2'd3; block = 0;
    marker = 11'd2000; diag_score = 0; diag_CH = 0;
    H_init_in = 0; D_init_in = 16'(NINF); global_max = -16'sd32768;
    valid_in = 0; ref_in = 0; ref_idx_in = 0; query_idx_in = 0;
    H_prev_pe = 16'(NINF); I_prev_pe = 16'(NINF); CH_prev_pe = 0; CI_prev_pe = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_H", H_out, NINF);
    checkOutput("rst_I", I_out, NINF);
    checkOutput("rst_D", D_out, NINF);
    checkOutput("rst_max", max_score, -32768);
    checkOutput("rst_busy", cfg_busy, 1);
    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_CH", CH_out, 0);
    rst_n = 1'b1;

    valid_in = 1'b1;
    tick();
    checkOutput("cfg_ignores_valid", valid_out, 0);
    valid_in = 1'b0;

    for (int s = 0; s < 32; s++) begin
      cfg_wr   = 1'b1;
      cfg_addr = 5'(s);
      cfg_data = (s == 0) ? 16'sd2 : -16'sd3;
      tick();
    end
    cfg_wr = 1'b0;
    commitScalars(1'b0);
    checkOutput("busy_after_commit", cfg_busy, 0);

    // PE0 boundary seeded on H at the origin cell.
    valid_in = 0; H_init_in = 0;
    tick();
    valid_in = 1; ref_in = 0; ref_idx_in = 0; query_idx_in = 0; init_state = 2'd0;
    tick();
    checkOutput("seed_H", H_out, 2);
    checkOutput("seed_dir", dir_out, 0);
    checkOutput("seed_valid", valid_out, 1);
    valid_in = 0; init_state = 2'd3;

    cfg_wr = 1; cfg_addr = 0; cfg_data = 16'sd100;
    tick();
    cfg_wr = 0;
    applyStimulus(0, 5'd0, 1, 1, 1'b0);
    checkOutput("run_wr_ignored", H_out, 2);

    // Gap chain from the row boundary: D wins via Dleft.
    valid_in = 0; H_init_in = 0;
    tick();
    valid_in = 1; ref_in = 5'd1; ref_idx_in = 1; query_idx_in = 1;
    H_init_in = 16'sd5; D_init_in = 16'sd3; H_prev_pe = 16'(NINF); I_prev_pe = 16'(NINF);
    tick();
    checkOutput("gap_H", H_out, 2);
    checkOutput("gap_dir", dir_out, 5);
    checkOutput("gap_D", D_out, 2);
    checkOutput("gap_I", I_out, NINF);
    valid_in = 0;

    // Vertical move: I opened from Hup, pointer taken from CH_prev_pe.
    H_init_in = 0;
    tick();
    valid_in = 1; ref_in = 5'd1; ref_idx_in = 2; query_idx_in = 1;
    H_init_in = 16'(NINF); D_init_in = 16'(NINF); H_prev_pe = 16'sd20; I_prev_pe = 16'(NINF);
    CH_prev_pe = 12'd37; CI_prev_pe = 12'd5;
    tick();
    checkOutput("ver_H", H_out, 16);
    checkOutput("ver_dir", dir_out, 2);
    checkOutput("ver_CH", CH_out, 37);
    checkOutput("ver_CI", CI_out, 37);
    valid_in = 0; CH_prev_pe = 0; CI_prev_pe = 0;

    commitScalars(1'b1);
    applyStimulus(-10, 5'd1, 6, 2, 1'b0);
    checkOutput("local_H", H_out, 0);
    checkOutput("local_dir", dir_out, 3);
    checkOutput("local_CH", CH_out, 27);
    checkOutput("local_busy", cfg_busy, 0);
    commitScalars(1'b0);

    marker = 11'd8;
    applyStimulus(0, 5'd0, 5, 3, 1'b0);
    checkOutput("conv_CH", CH_out, 20);
    checkOutput("conv_CI", CI_out, 21);
    checkOutput("conv_CD", CD_out, 22);
    applyStimulus(0, 5'd0, 4, 3, 1'b0);
    checkOutput("conv_m1_CH", CH_out, 19);
    checkOutput("conv_m1_CI", CI_out, 19);
    checkOutput("conv_m1_CD", CD_out, 19);
    marker = 11'd2000;

    global_max = 16'sd50;
    applyStimulus(42, 5'd1, 1, 1, 1'b0);
    checkOutput("xd39_H", H_out, 39);
    checkOutput("xd39_flag", xdrop_flag, 1);
    applyStimulus(43, 5'd1, 1, 1, 1'b0);
    checkOutput("xd40_H", H_out, 40);
    checkOutput("xd40_flag", xdrop_flag, 0);
    global_max = -16'sd32768;

    tile_start = 1;
    tick();
    tile_start = 0;
    checkOutput("max_cleared", max_score, -32768);
    applyStimulus(1, 5'd0, 1, 1, 1'b0);
    applyStimulus(5, 5'd0, 2, 1, 1'b0);
    applyStimulus(5, 5'd0, 3, 1, 1'b0);
    applyStimulus(0, 5'd0, 4, 1, 1'b0);
    checkOutput("max_score", max_score, 7);
    checkOutput("max_ref_idx", max_ref_idx, 2);
    checkOutput("max_query_idx", max_query_idx, 1);
    applyStimulus(7, 5'd0, 5, 1, 1'b1);
    checkOutput("ts_H", H_out, 9);
    checkOutput("ts_max", max_score, -32768);

    // Asynchronous reset while a cell is in flight.
    applyStimulus(5, 5'd0, 6, 1, 1'b0);
    valid_in = 1;
    rst_n = 1'b0;
    #2;
    checkOutput("arst_H", H_out, NINF);
    checkOutput("arst_valid", valid_out, 0);
    checkOutput("arst_busy", cfg_busy, 1);
    checkOutput("arst_max", max_score, -32768);
    valid_in = 0;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
